// File: rtl/neuron_mac_pkg.sv
// neuron_mac_pkg: state encoding and default sizes for the neuron MAC controller.
package neuron_mac_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ACC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam int N_MAX_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int CNT_W_DEF  = 5;
  localparam int ACC_W      = 16;
  localparam int BIAS_W     = 8;
endpackage

// File: rtl/neuron_mac_ctrl_term_counter.sv
// term_counter: operand term counter with a last-term flag against the latched count.
module term_counter
  import neuron_mac_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] n,
  output logic [CNT_W-1:0] count,
  output logic             last
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= clear ? '0 : enable ? count + CNT_W'(1) : count;
  assign last = count == n - CNT_W'(1);
endmodule

// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: bias-init / multiply-accumulate sequencer for one neuron; NEURON_MAC_CTRL_PIPE_EN adds a one-cycle ld_reg lag and a DRAIN state.
module neuron_mac_ctrl
  import neuron_mac_pkg::*;
#(
  parameter int N_MAX  = N_MAX_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              stall,
  output logic              init,
  output logic              ld_reg,
  output logic [ADDR_W-1:0] addr,
  output logic              busy,
  output logic              done
);
  state_t           state;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             issue;
  assign issue = state == ACC && !stall;
  term_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state != ACC || (issue && last)),
    .enable (issue),
    .n      (n_lat),
    .count  (cnt),
    .last   (last)
  );
  assign addr = ADDR_W'(cnt);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      n_lat <= '0;
      init  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      init <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          n_lat <= n_terms > CNT_W'(N_MAX) ? CNT_W'(N_MAX) : n_terms;
          state <= INIT;
          init  <= 1'b1;
          busy  <= 1'b1;
        end
        INIT: if (n_lat != '0) state <= ACC;
        else begin
          state <= DONE;
          done  <= 1'b1;
        end
`ifdef NEURON_MAC_CTRL_PIPE_EN
        ACC: if (issue && last) state <= DRAIN;
        DRAIN: if (!stall) begin
          state <= DONE;
          done  <= 1'b1;
        end
`else
        ACC: if (issue && last) begin
          state <= DONE;
          done  <= 1'b1;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef NEURON_MAC_CTRL_PIPE_EN
  // A stalled term keeps its pending load until the operand arrives.
  logic vld;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld <= 1'b0;
    else vld <= (stall && (state == ACC || state == DRAIN)) ? vld : issue;
  assign ld_reg = vld && !stall;
`else
  assign ld_reg = issue;
`endif
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// tb_neuron_mac_ctrl: directed checks of neuron_mac_ctrl, both with and without NEURON_MAC_CTRL_PIPE_EN.
module tb_neuron_mac_ctrl;
`ifdef NEURON_MAC_CTRL_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [4:0] n_terms = '0;
  logic       stall = 1'b0;
  logic       init, ld_reg, busy, done;
  logic [3:0] addr;
  int         checks = 0;
  int         failures = 0;
  int         excl = 0;
  logic [31:0] ld_m, init_m, done_m, busy_m;
  logic [63:0] addr_tr;
  int          addr_sum, ld_cnt;

  neuron_mac_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .n_terms (n_terms),
    .stall   (stall),
    .init    (init),
    .ld_reg  (ld_reg),
    .addr    (addr),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycle c is the clock period after edge E(c-1); start is sampled at E0.
  task automatic run(input int n, input logic [31:0] stall_m, input logic [31:0] start_m, input int ncyc);
    ld_m = '0; init_m = '0; done_m = '0; busy_m = '0; addr_tr = '0;
    addr_sum = 0; ld_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    n_terms = 5'(n);
    @(posedge clk);
    #1;
    for (int c = 1; c <= ncyc; c++) begin
      start = start_m[c];
      stall = stall_m[c];
      @(negedge clk);
      ld_m[c] = ld_reg;
      init_m[c] = init;
      done_m[c] = done;
      busy_m[c] = busy;
      if (c < 16) addr_tr[4*c +: 4] = addr;
      addr_sum += int'(addr);
      ld_cnt += int'(ld_reg);
      if (init && ld_reg) excl++;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #12;
    check("reset_outs", {init, ld_reg, addr, busy, done}, 8'h0);
    rst_n = 1'b1;
    run(3, 32'h0, 32'h0, 8);
    check("basic_init", init_m, 32'h2);
    check("basic_ld", ld_m, PIPE ? 32'h38 : 32'h1C);
    check("basic_done", done_m, PIPE ? 32'h40 : 32'h20);
    check("basic_busy", busy_m, PIPE ? 32'h7E : 32'h3E);
    check("basic_addr", addr_tr, 64'h21000);
    run(0, 32'h0, 32'h0, 5);
    check("zero_init", init_m, 32'h2);
    check("zero_ld", ld_m, 32'h0);
    check("zero_done", done_m, 32'h4);
    check("zero_busy", busy_m, 32'h6);
    run(4, 32'h18, 32'h0, 11);
    check("stall_ld", ld_m, PIPE ? 32'h1E0 : 32'hE4);
    check("stall_done", done_m, PIPE ? 32'h200 : 32'h100);
    check("stall_addr", addr_tr, 64'h32111000);
    run(3, 32'h0, PIPE ? 32'h48 : 32'h28, 10);
    check("busy_ign_busy", busy_m, PIPE ? 32'h7E : 32'h3E);
    check("busy_ign_done", done_m, PIPE ? 32'h40 : 32'h20);
    run(2, 32'h0, 32'h0, 7);
    check("after_ign_done", done_m, PIPE ? 32'h20 : 32'h10);
    check("after_ign_ld", ld_m, PIPE ? 32'h18 : 32'hC);
    run(16, 32'h0, 32'h0, 22);
    check("full_ld", ld_m, PIPE ? 32'h7FFF8 : 32'h3FFFC);
    check("full_done", done_m, PIPE ? 32'h80000 : 32'h40000);
    check("full_addr_sum", 64'(addr_sum), 64'd120);
    check("full_ld_cnt", 64'(ld_cnt), 64'd16);
    run(20, 32'h0, 32'h0, 22);
    check("clamp_ld", ld_m, PIPE ? 32'h7FFF8 : 32'h3FFFC);
    check("clamp_done", done_m, PIPE ? 32'h80000 : 32'h40000);
    check("clamp_addr_sum", 64'(addr_sum), 64'd120);
    check("clamp_ld_cnt", 64'(ld_cnt), 64'd16);
    @(negedge clk);
    start = 1'b1;
    n_terms = 5'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_pre_addr", 64'(addr), 64'd2);
    check("rst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async", {init, ld_reg, addr, busy, done}, 8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(2, 32'h0, 32'h0, 7);
    check("rst_post_ld", ld_m, PIPE ? 32'h18 : 32'hC);
    check("rst_post_done", done_m, PIPE ? 32'h20 : 32'h10);
    check("strobe_excl", 64'(excl), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neuron_mac_ctrl.md
Name: neuron_mac_ctrl

Overview:
- Sequencing controller for one neuron's 16-bit accumulator register.
- On `start`, it pulses `init` so the accumulator loads the sign-extended 8-bit bias.
- It then issues `n_terms` operand addresses and asserts `ld_reg` once per product term, so the accumulator captures each partial sum.
- Finally it pulses `done`. It sits between the layer scheduler and the neuron datapath (weight/input memories, multiplier, adder, accumulator).

Parameters:
- N_MAX, 16: maximum number of product terms per neuron.
- ADDR_W, 4: width of the operand address; must satisfy 2**ADDR_W >= N_MAX.
- CNT_W, 5: width of `n_terms`; must hold the value N_MAX.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin one neuron evaluation; sampled only in IDLE.
- n_terms  in  CNT_W  number of product terms; sampled with `start`; legal range 0..N_MAX.
- stall  in  1  operand not yet available; freezes address issue while high.
- init  out  1  accumulator load-bias strobe.
- ld_reg  out  1  accumulator load-sum strobe.
- addr  out  ADDR_W  weight/input index of the current term.
- busy  out  1  high from the INIT cycle through the DONE cycle inclusive.
- done  out  1  one-cycle pulse; the accumulator holds the final sum.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, init=0, ld_reg=0, addr=0, busy=0, done=0, term counter=0, latched count=0.
- Reset mid-operation: reset aborts immediately to these values. The accumulator contents are then don't-care.
- FSM states: IDLE, INIT, ACC, DRAIN, DONE.
- IDLE:
  - If `start`=1, latch `n_terms` and go to INIT.
  - `start` while `busy` is ignored. No queueing.
- INIT:
  - init=1 for exactly one cycle. addr=0.
  - Next state is ACC if latched count > 0; otherwise DONE (result = bias).
- ACC:
  - Each cycle with stall=0: present addr=k, assert ld_reg=1, then increment k.
  - With stall=1: addr holds, ld_reg=0, k is unchanged.
  - After the cycle that issues k = count-1, go to DONE.
  - DRAIN is used only with the optional feature.
- DONE:
  - done=1 for one cycle, addr returns to 0, then go to IDLE.
  - `start` is not accepted in DONE. The earliest accepted `start` is the cycle after DONE.
- Strobe exclusivity: init and ld_reg are never high in the same cycle.
- Latency with no stalls: start sampled at edge E0; init high in cycle 1; ld_reg high in cycles 2..n+1; done high in cycle n+2.
- Counter width: the term counter is CNT_W wide; addr is its low ADDR_W bits.
- Out-of-range count: n_terms > N_MAX is clamped to N_MAX at latch time.
- `stall` is ignored outside ACC (and outside DRAIN when the optional feature is enabled).

Optional Feature:
- Macro: NEURON_MAC_CTRL_PIPE_EN.
- Defined: for registered (1-cycle-latency) operand memories.
  - ld_reg is addr-valid delayed by one cycle through a register, so ld_reg for term k rises one cycle after addr=k.
  - After the last address is issued, the FSM spends one DRAIN cycle asserting the final ld_reg.
  - DRAIN honours `stall`: it holds while stall=1. The delayed ld_reg is suppressed while stall=1.
  - Total latency becomes n+3 cycles; done is in cycle n+3.
- Undefined: the DRAIN state and the delay register are absent; timing is as stated in Behaviour.

Decomposition:
- Package `neuron_mac_pkg` contains:
  - the state encoding constants (IDLE=0, INIT=1, ACC=2, DRAIN=3, DONE=4), 3-bit;
  - the default N_MAX, ADDR_W and CNT_W;
  - the accumulator width constant 16 and the bias width constant 8.
- Sub-module: `term_counter` holds the CNT_W-bit counter.
  - Inputs: clear, enable.
  - Outputs: count and `last` (count == latched_n-1).
  - Instantiated once.

Test Plan:
- Basic run: reset, then start=1 with n_terms=3, stall=0 -> init in cycle 1; ld_reg in cycles 2–4 with addr 0,1,2; done in cycle 5; busy high cycles 1–5.
- Zero terms: n_terms=0 -> init in cycle 1; done in cycle 2; ld_reg never asserted.
- Stall mid-accumulation: n_terms=4, stall=1 during cycles 3–4 -> addr holds at 1 for cycles 3–5; ld_reg low in cycles 3–4; done in cycle 8.
- Start while busy: start pulses during ACC and during DONE are ignored; the next start after DONE is accepted normally.
- Full length and clamping: n_terms=16 -> addr runs 0..15 with 16 ld_reg pulses, then addr returns to 0. n_terms=20 -> behaviour identical to 16.
- Reset mid-run: deassert rst_n asynchronously during ACC at addr=2 -> all outputs go to 0 immediately, without waiting for a clock edge. After release, start with n=2 runs cleanly.
- Repeat all of the above with NEURON_MAC_CTRL_PIPE_EN defined, checking the +1 ld_reg lag and the DRAIN cycle.
